// File: rtl/alu_ctrl_seq.sv
`default_nettype none
// ============================================================================
//  Module   : alu_ctrl_seq
//  Purpose  : Registered, handshaked ALU/MDU control decoder. Decodes
//             alu_op/funct_3/funct_7 (RV32I + optional RV32M) into a control
//             code, sequences multi-cycle MUL/DIV latency and drives an
//             operand-isolation enable for the datapath.
//  Revision : 1.0 - initial release
// ============================================================================
module alu_ctrl_seq #(
  parameter int CTRL_W  = 5,
  parameter int M_EN    = 1,
  parameter int MUL_LAT = 2,
  parameter int DIV_LAT = 33
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        alu_op,
  input  logic [2:0]        funct_3,
  input  logic [6:0]        funct_7,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] alu_control,
  output logic              illegal,
  output logic              busy,
  output logic              alu_en
);

  // Counter holds at most LAT-1, so clog2 of the larger latency is enough.
  localparam int c_max_lat = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int c_cnt_w   = (c_max_lat > 1) ? $clog2(c_max_lat) : 1;

  localparam logic [6:0] c_f7_base = 7'b0000000;
  localparam logic [6:0] c_f7_alt  = 7'b0100000;
  localparam logic [6:0] c_f7_m    = 7'b0000001;

  localparam logic [4:0] c_code_branch = 5'd10;
  localparam logic [4:0] c_code_m_base = 5'd11;

  typedef enum logic [1:0] {
    c_st_idle = 2'd0,
    c_st_run  = 2'd1,
    c_st_hold = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [c_cnt_w-1:0]  r_cnt;
  logic [c_cnt_w-1:0]  w_cnt_nxt;
  logic [CTRL_W-1:0]   r_ctrl;
  logic                r_illegal;
  logic                r_out_valid;
  logic                r_busy;
  logic                r_alu_en;

  logic [4:0]          w_code;
  logic                w_illegal;
  logic                w_is_mul;
  logic                w_is_div;
  logic                w_multi;
  logic [c_cnt_w-1:0]  w_lat_m1;
  logic                w_in_ready;
  logic                w_accept;

  // Shared funct3 mapping for the base integer ops (ADD/SLL/SLT/SLTU/XOR/SRL/OR/AND).
  function automatic logic [4:0] base_code(input logic [2:0] f3);
    logic [4:0] code;
    case (f3)
      3'd0:    code = 5'd0;
      3'd1:    code = 5'd5;
      3'd2:    code = 5'd8;
      3'd3:    code = 5'd9;
      3'd4:    code = 5'd2;
      3'd5:    code = 5'd6;
      3'd6:    code = 5'd3;
      default: code = 5'd4;
    endcase
    return code;
  endfunction

  // Instruction decode: control code, illegal flag and latency class.
  always_comb begin
    w_code    = 5'd0;
    w_illegal = 1'b0;
    w_is_mul  = 1'b0;
    w_is_div  = 1'b0;
    case (alu_op)
      2'b00: w_code = 5'd0;
      2'b01: w_code = c_code_branch;
      2'b10: begin
        if (funct_7 == c_f7_base) begin
          w_code = base_code(funct_3);
        end else if (funct_7 == c_f7_alt) begin
          if (funct_3 == 3'd0)      w_code = 5'd1;
          else if (funct_3 == 3'd5) w_code = 5'd7;
          else                      w_illegal = 1'b1;
        end else if ((funct_7 == c_f7_m) && (M_EN != 0)) begin
          w_code   = c_code_m_base + {2'b00, funct_3};
          w_is_mul = ~funct_3[2];
          w_is_div = funct_3[2];
        end else begin
          w_illegal = 1'b1;
        end
      end
      default: begin
        if (funct_3 == 3'd5) begin
          if (funct_7 == c_f7_base)     w_code = 5'd6;
          else if (funct_7 == c_f7_alt) w_code = 5'd7;
          else                          w_illegal = 1'b1;
        end else begin
          w_code = base_code(funct_3);
        end
      end
    endcase
  end

  // Latency selection; a latency of 1 behaves exactly like a single-cycle op.
  always_comb begin
    w_multi  = 1'b0;
    w_lat_m1 = '0;
    if (w_is_mul) begin
      w_multi  = (MUL_LAT > 1);
      w_lat_m1 = c_cnt_w'(MUL_LAT - 1);
    end else if (w_is_div) begin
      w_multi  = (DIV_LAT > 1);
      w_lat_m1 = c_cnt_w'(DIV_LAT - 1);
    end
  end

  // Ready depends only on state, out_ready and flush, never on in_valid.
  always_comb begin
    w_in_ready = ~flush & ((r_state == c_st_idle) |
                           ((r_state == c_st_hold) & out_ready));
    w_accept   = in_valid & w_in_ready;
  end

  // Next-state and counter logic; flush overrides everything but reset.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    if (flush) begin
      w_state_nxt = c_st_idle;
      w_cnt_nxt   = '0;
    end else begin
      case (r_state)
        c_st_run: begin
          if (r_cnt <= c_cnt_w'(1)) begin
            w_state_nxt = c_st_hold;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = r_cnt - c_cnt_w'(1);
          end
        end
        c_st_hold, c_st_idle: begin
          if (w_accept) begin
            if (w_multi) begin
              w_state_nxt = c_st_run;
              w_cnt_nxt   = w_lat_m1;
            end else begin
              w_state_nxt = c_st_hold;
            end
          end else if ((r_state == c_st_hold) && out_ready) begin
            w_state_nxt = c_st_idle;
          end
        end
        default: begin
          w_state_nxt = c_st_idle;
          w_cnt_nxt   = '0;
        end
      endcase
    end
  end

  // State register plus glitch-free registered status flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= c_st_idle;
      r_cnt       <= '0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_alu_en    <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_out_valid <= (w_state_nxt == c_st_hold);
      r_busy      <= (w_state_nxt == c_st_run);
      r_alu_en    <= (w_state_nxt != c_st_idle);
    end
  end

  // Control code captured only on accept so it stays quiet while idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ctrl    <= '0;
      r_illegal <= 1'b0;
    end else if (w_accept) begin
      r_ctrl    <= CTRL_W'(w_code);
      r_illegal <= w_illegal;
    end
  end

  assign in_ready    = w_in_ready;
  assign out_valid   = r_out_valid;
  assign busy        = r_busy;
  assign alu_en      = r_alu_en;
  assign alu_control = r_ctrl;
  assign illegal     = r_illegal;

endmodule
`default_nettype wire

// File: tb/tb_alu_ctrl_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alu_ctrl_seq
//  Purpose  : Self-checking bench for alu_ctrl_seq with an expected-result
//             queue filled on accept and drained on retire.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_alu_ctrl_seq;

  localparam int CTRL_W = 5;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid, in_valid2;
  logic              in_ready, in_ready2;
  logic [1:0]        alu_op;
  logic [2:0]        funct_3;
  logic [6:0]        funct_7;
  logic              flush;
  logic              out_valid, out_valid2;
  logic              out_ready, out_ready2;
  logic [CTRL_W-1:0] alu_control, alu_control2;
  logic              illegal, illegal2;
  logic              busy, busy2;
  logic              alu_en, alu_en2;

  logic [CTRL_W-1:0] exp_code;
  logic              exp_ill;
  logic [CTRL_W:0]   sb_q[$];

  int n_total = 0;
  int n_bad   = 0;

  alu_ctrl_seq #(.CTRL_W(CTRL_W), .M_EN(1), .MUL_LAT(4), .DIV_LAT(33)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .alu_op(alu_op), .funct_3(funct_3), .funct_7(funct_7), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .alu_control(alu_control),
    .illegal(illegal), .busy(busy), .alu_en(alu_en)
  );

  alu_ctrl_seq #(.CTRL_W(CTRL_W), .M_EN(0), .MUL_LAT(2), .DIV_LAT(33)) u_dut_nom (
    .clk(clk), .rst(rst), .in_valid(in_valid2), .in_ready(in_ready2),
    .alu_op(alu_op), .funct_3(funct_3), .funct_7(funct_7), .flush(1'b0),
    .out_valid(out_valid2), .out_ready(out_ready2), .alu_control(alu_control2),
    .illegal(illegal2), .busy(busy2), .alu_en(alu_en2)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] op, input logic [2:0] f3, input logic [6:0] f7,
                       input logic [CTRL_W-1:0] code, input logic ill);
    in_valid = 1'b1;
    alu_op   = op;
    funct_3  = f3;
    funct_7  = f7;
    exp_code = code;
    exp_ill  = ill;
  endtask

  // Scoreboard: retire (pop) before capturing a newly accepted op (push).
  always @(negedge clk) begin
    if (rst || flush) begin
      sb_q.delete();
    end else begin
      if (out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          chk("sb_spurious", 32'(out_valid), 32'd0);
        end else begin
          logic [CTRL_W:0] e;
          e = sb_q.pop_front();
          chk("sb_code", 32'(alu_control), 32'(e[CTRL_W-1:0]));
          chk("sb_ill", 32'(illegal), 32'(e[CTRL_W]));
        end
      end
      if (in_valid && in_ready) sb_q.push_back({exp_ill, exp_code});
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  typedef struct packed {
    logic [1:0]        op;
    logic [2:0]        f3;
    logic [6:0]        f7;
    logic [CTRL_W-1:0] code;
    logic              ill;
  } vec_t;

  vec_t tbl[12];

  initial begin
    int n, nb, nir, nstab;

    tbl[0]  = '{2'b11, 3'd0, 7'b0100000, 5'd0,  1'b0};
    tbl[1]  = '{2'b10, 3'd4, 7'b0100000, 5'd0,  1'b1};
    tbl[2]  = '{2'b11, 3'd5, 7'b0000000, 5'd6,  1'b0};
    tbl[3]  = '{2'b11, 3'd5, 7'b0100000, 5'd7,  1'b0};
    tbl[4]  = '{2'b11, 3'd5, 7'b0000001, 5'd0,  1'b1};
    tbl[5]  = '{2'b11, 3'd1, 7'b1111111, 5'd5,  1'b0};
    tbl[6]  = '{2'b10, 3'd2, 7'b0000000, 5'd8,  1'b0};
    tbl[7]  = '{2'b10, 3'd6, 7'b0000000, 5'd3,  1'b0};
    tbl[8]  = '{2'b10, 3'd1, 7'b0000000, 5'd5,  1'b0};
    tbl[9]  = '{2'b10, 3'd0, 7'b1111111, 5'd0,  1'b1};
    tbl[10] = '{2'b00, 3'd3, 7'b0101010, 5'd0,  1'b0};
    tbl[11] = '{2'b01, 3'd0, 7'b0000000, 5'd10, 1'b0};

    // Reset held two cycles with an op presented.
    rst = 1'b1; flush = 1'b0; out_ready = 1'b0; out_ready2 = 1'b1; in_valid2 = 1'b0;
    drive(2'b10, 3'd0, 7'b0000000, 5'd0, 1'b0);
    tick(); tick();
    rst = 1'b0; in_valid = 1'b0;
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_alu_control", 32'(alu_control), 32'd0);
    chk("rst_alu_en", 32'(alu_en), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);

    // Back-to-back ADD, SUB, SRA.
    out_ready = 1'b1;
    drive(2'b10, 3'd0, 7'b0000000, 5'd0, 1'b0); tick();
    chk("b2b_valid0", 32'(out_valid), 32'd1);
    drive(2'b10, 3'd0, 7'b0100000, 5'd1, 1'b0); tick();
    chk("b2b_valid1", 32'(out_valid), 32'd1);
    drive(2'b10, 3'd5, 7'b0100000, 5'd7, 1'b0); tick();
    chk("b2b_valid2", 32'(out_valid), 32'd1);
    chk("b2b_code2", 32'(alu_control), 32'd7);
    in_valid = 1'b0; tick();
    chk("b2b_idle", 32'(out_valid), 32'd0);

    // DIV: 32 busy cycles, result 33 cycles after accept.
    drive(2'b10, 3'd4, 7'b0000001, 5'd15, 1'b0);
    #1;
    chk("div_accept_ready", 32'(in_ready), 32'd1);
    tick(); in_valid = 1'b0;
    n = 0; nb = 0; nir = 0; nstab = 0;
    while (!out_valid && n < 40) begin
      if (busy) nb++;
      if (in_ready) nir++;
      if (alu_control != 5'd15) nstab++;
      tick(); n++;
    end
    chk("div_latency", 32'(n), 32'd32);
    chk("div_busy_cycles", 32'(nb), 32'd32);
    chk("div_ready_in_run", 32'(nir), 32'd0);
    chk("div_ctrl_stable", 32'(nstab), 32'd0);
    chk("div_alu_en", 32'(alu_en), 32'd1);
    tick();

    // Held SLTU under backpressure, then ANDI accepted on the retire cycle.
    out_ready = 1'b0;
    drive(2'b10, 3'd3, 7'b0000000, 5'd9, 1'b0); tick();
    in_valid = 1'b0;
    nb = 0; nir = 0; nstab = 0;
    for (int i = 0; i < 3; i++) begin
      if (out_valid) nb++;
      if (in_ready) nir++;
      if (alu_control != 5'd9) nstab++;
      tick();
    end
    chk("hold_valid_cycles", 32'(nb), 32'd3);
    chk("hold_ready", 32'(nir), 32'd0);
    chk("hold_stable", 32'(nstab), 32'd0);
    out_ready = 1'b1;
    drive(2'b11, 3'd7, 7'b1010101, 5'd4, 1'b0);
    #1;
    chk("hold_release_ready", 32'(in_ready), 32'd1);
    tick(); in_valid = 1'b0;
    chk("andi_code", 32'(alu_control), 32'd4);
    chk("andi_valid", 32'(out_valid), 32'd1);
    tick();

    // MULHU with latency 4.
    drive(2'b10, 3'd3, 7'b0000001, 5'd14, 1'b0); tick(); in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 20) begin tick(); n++; end
    chk("mul_latency", 32'(n), 32'd3);
    tick();

    // Flush a MUL mid-flight while another op is presented.
    drive(2'b10, 3'd0, 7'b0000001, 5'd11, 1'b0); tick(); in_valid = 1'b0;
    tick();
    chk("mul_busy", 32'(busy), 32'd1);
    flush = 1'b1;
    drive(2'b10, 3'd0, 7'b0000000, 5'd0, 1'b0);
    tick();
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_valid", 32'(out_valid), 32'd0);
    chk("flush_busy", 32'(busy), 32'd0);
    chk("flush_alu_en", 32'(alu_en), 32'd0);
    nb = 0;
    for (int i = 0; i < 8; i++) begin
      if (out_valid) nb++;
      tick();
    end
    chk("flush_no_pulse", 32'(nb), 32'd0);

    // Flush while idle blocks acceptance.
    flush = 1'b1;
    drive(2'b10, 3'd0, 7'b0000000, 5'd0, 1'b0);
    #1;
    chk("flush_in_ready", 32'(in_ready), 32'd0);
    tick(); flush = 1'b0; in_valid = 1'b0;
    chk("flush_no_accept", 32'(out_valid), 32'd0);

    // M extension disabled: MUL decodes illegal with code 0.
    alu_op = 2'b10; funct_3 = 3'd0; funct_7 = 7'b0000001;
    in_valid2 = 1'b1;
    #1;
    chk("nom_ready", 32'(in_ready2), 32'd1);
    tick(); in_valid2 = 1'b0;
    chk("nom_valid", 32'(out_valid2), 32'd1);
    chk("nom_illegal", 32'(illegal2), 32'd1);
    chk("nom_code", 32'(alu_control2), 32'd0);
    chk("nom_busy", 32'(busy2), 32'd0);
    chk("nom_alu_en", 32'(alu_en2), 32'd1);
    tick();

    // Decode table, streamed back-to-back.
    out_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      drive(tbl[i].op, tbl[i].f3, tbl[i].f7, tbl[i].code, tbl[i].ill);
      tick();
    end
    in_valid = 1'b0; tick();
    chk("idle_hold_code", 32'(alu_control), 32'd10);
    chk("idle_alu_en", 32'(alu_en), 32'd0);

    // Reset in the middle of RUN.
    drive(2'b10, 3'd5, 7'b0000001, 5'd16, 1'b0); tick(); in_valid = 1'b0;
    tick();
    chk("pre_rst_busy", 32'(busy), 32'd1);
    rst = 1'b1; tick(); rst = 1'b0;
    #1;
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_code", 32'(alu_control), 32'd0);
    chk("mid_rst_ready", 32'(in_ready), 32'd1);
    tick();

    chk("sb_drain", 32'(sb_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
